// File: rtl/detector_jogada_pkg.sv
// Shared constants, state codes and helpers for the move detector
// that feeds the game control unit.
package detector_jogada_pkg;

    localparam int unsigned CHAVES_W            = 4;
    localparam int unsigned CNT_W               = 4;
    localparam int unsigned ESTADO_W            = 4;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;

    typedef enum logic [ESTADO_W-1:0] {
        OCIOSO     = 4'd0,
        ESTABILIZA = 4'd1,
        REGISTRA   = 4'd2,
        SOLTURA    = 4'd3
    } estado_t;

    // True when exactly one switch is set.
    function automatic logic is_one_hot(input logic [CHAVES_W-1:0] v);
        return (v != '0) && ((v & (v - CHAVES_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/detector_jogada_if.sv
// Switch inputs, control qualifiers and move outputs between the
// player-facing side and the detector.
interface detector_jogada_if;
    import detector_jogada_pkg::*;

    logic [CHAVES_W-1:0] chaves;
    logic                habilita;
    logic                limpa;
    logic [CHAVES_W-1:0] jogada;
    logic                tem_jogada;
    logic                jogada_invalida;
    logic [ESTADO_W-1:0] db_estado;

    modport master (
        output chaves, habilita, limpa,
        input  jogada, tem_jogada, jogada_invalida, db_estado
    );

    modport slave (
        input  chaves, habilita, limpa,
        output jogada, tem_jogada, jogada_invalida, db_estado
    );

endinterface

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer bringing the asynchronous switch vector into
// the clock domain; output lags the input by two rising edges.
module sincronizador_2ff #(
    parameter int unsigned W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/detector_jogada.sv
// Debounces the player switches and emits one accepted move (or one
// invalid-press flag) per press/release cycle.
module detector_jogada
    import detector_jogada_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic              clock,
    input  logic              reset,
    detector_jogada_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    estado_t             estado;
    logic [CHAVES_W-1:0] chaves_s;
    logic [CHAVES_W-1:0] sample;
    logic [CNT_W-1:0]    cnt;
    logic [CHAVES_W-1:0] jogada_q;
    logic                tem_jogada_q;
    logic                jogada_invalida_q;

    sincronizador_2ff #(
        .W (CHAVES_W)
    ) u_sincronizador (
        .clock (clock),
        .reset (reset),
        .d     (bus.chaves),
        .q     (chaves_s)
    );

    // Pulses are set on the edge entering REGISTRA so they are high for
    // exactly the one cycle the FSM spends there.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado            <= OCIOSO;
            sample            <= '0;
            cnt               <= '0;
            jogada_q          <= '0;
            tem_jogada_q      <= 1'b0;
            jogada_invalida_q <= 1'b0;
        end else begin
            tem_jogada_q      <= 1'b0;
            jogada_invalida_q <= 1'b0;

            case (estado)
                OCIOSO: begin
                    if (bus.habilita && (chaves_s != '0)) begin
                        estado <= ESTABILIZA;
                        sample <= chaves_s;
                        cnt    <= '0;
                    end
                end

                ESTABILIZA: begin
                    if (chaves_s == '0) begin
                        estado <= OCIOSO;
                    end else if (chaves_s != sample) begin
                        sample <= chaves_s;
                        cnt    <= '0;
                    end else if (!bus.habilita) begin
                        estado <= OCIOSO;
                    end else if (cnt == CNT_MAX) begin
                        estado            <= REGISTRA;
                        tem_jogada_q      <= is_one_hot(sample);
                        jogada_invalida_q <= !is_one_hot(sample);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                REGISTRA: begin
                    if (is_one_hot(sample)) begin
                        jogada_q <= sample;
                    end
                    estado <= SOLTURA;
                    cnt    <= '0;
                end

                SOLTURA: begin
                    // Any held or changed press restarts the release window.
                    if (chaves_s != '0) begin
                        cnt <= '0;
                    end else if (cnt == CNT_MAX) begin
                        estado <= OCIOSO;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    estado <= OCIOSO;
                end
            endcase

            // New-game clear overrides a simultaneous load.
            if (bus.limpa) begin
                jogada_q <= '0;
            end
        end
    end

    assign bus.jogada          = jogada_q;
    assign bus.tem_jogada      = tem_jogada_q;
    assign bus.jogada_invalida = jogada_invalida_q;
    assign bus.db_estado       = ESTADO_W'(estado);

endmodule
